// File: rtl/deconv_sched_pkg.sv
// Shared types and sizing helpers for the deconv read scheduler.
// The ERR state exists only when DECONV_READ_SCHEDULER_TIMEOUT_EN is defined.
package deconv_sched_pkg;

  localparam int DEF_SIZE_OF_WEIGHT  = 3;
  localparam int DEF_SIZE_OF_FEATURE = 4;
  localparam int W_PIX = DEF_SIZE_OF_WEIGHT * DEF_SIZE_OF_WEIGHT;
  localparam int F_PIX = DEF_SIZE_OF_FEATURE * DEF_SIZE_OF_FEATURE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_REQ,
    S_W_WAIT,
    S_F_REQ,
    S_F_WAIT,
    S_C_START,
    S_C_WAIT,
    S_FIN
`ifdef DECONV_READ_SCHEDULER_TIMEOUT_EN
    , S_ERR
`endif
  } sched_state_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lane_valid_collector.sv
// Sticky per-lane valid mask; all_seen is high once every lane has returned
// data for the outstanding read, including lanes valid in the current cycle.
module lane_valid_collector #(
  parameter int N_LANES = 4
)(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [N_LANES-1:0] i_valid,
  output logic               o_all_seen
);

  logic [N_LANES-1:0] mask_q, mask_d;

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    always_comb begin
      mask_d[l] = mask_q[l];
      if (i_clr)     mask_d[l] = 1'b0;
      else if (i_en) mask_d[l] = mask_q[l] | i_valid[l];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) mask_q[l] <= 1'b0;
      else          mask_q[l] <= mask_d[l];
    end
  end

  assign o_all_seen = &(mask_q | i_valid);

endmodule

// File: rtl/deconv_read_scheduler.sv
// Per-channel sequencer: weight reads, feature reads, then compute handshake.
// Define DECONV_READ_SCHEDULER_TIMEOUT_EN to add the wait-state watchdog and ERR state.
module deconv_read_scheduler
  import deconv_sched_pkg::*;
#(
  parameter int SIZE_OF_WEIGHT             = DEF_SIZE_OF_WEIGHT,
  parameter int SIZE_OF_FEATURE            = DEF_SIZE_OF_FEATURE,
  parameter int NUM_OF_CHANNEL_EACH_KERNEL = 1,
  parameter int N_LANES                    = 4,
  parameter int TIMEOUT_CYCLES             = 256
)(
  input  logic                                             i_clk,
  input  logic                                             i_rst_n,
  input  logic                                             i_start,
  input  logic                                             i_abort,
  output logic [N_LANES-1:0]                               o_weight_rd_en,
  input  logic [N_LANES-1:0]                               i_weight_rd_valid,
  output logic [N_LANES-1:0]                               o_feature_rd_en,
  input  logic [N_LANES-1:0]                               i_feature_rd_valid,
  output logic                                             o_compute_start,
  input  logic                                             i_compute_done,
  output logic [$clog2(NUM_OF_CHANNEL_EACH_KERNEL+1)-1:0]  o_channel_idx,
  output logic [$clog2(SIZE_OF_FEATURE*SIZE_OF_FEATURE+1)-1:0] o_pix_idx,
  output logic                                             o_busy,
  output logic                                             o_done,
  output logic                                             o_error
);

  localparam int WP    = SIZE_OF_WEIGHT * SIZE_OF_WEIGHT;
  localparam int FP    = SIZE_OF_FEATURE * SIZE_OF_FEATURE;
  localparam int NCH   = NUM_OF_CHANNEL_EACH_KERNEL;
  localparam int PIX_W = cnt_w(FP);
  localparam int CNT_W = cnt_w((WP > FP) ? WP : FP);
  localparam int CH_W  = cnt_w(NCH);

  if (N_LANES != 4 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("deconv_read_scheduler: unsupported N_LANES or TIMEOUT_CYCLES");
  end

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CH_W-1:0]  ch_q, ch_d;

  logic               coll_en, coll_clr, all_seen;
  logic [N_LANES-1:0] coll_valid;

  // One collector serves both read phases; the state picks which valids feed it.
  assign coll_en    = (state_q == S_W_WAIT) || (state_q == S_F_WAIT);
  assign coll_valid = (state_q == S_F_WAIT) ? i_feature_rd_valid : i_weight_rd_valid;
  assign coll_clr   = i_abort || (coll_en && (state_d != state_q));

  lane_valid_collector #(.N_LANES(N_LANES)) u_collector (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (coll_clr),
    .i_en       (coll_en),
    .i_valid    (coll_valid),
    .o_all_seen (all_seen)
  );

`ifdef DECONV_READ_SCHEDULER_TIMEOUT_EN
  localparam int WD_W = cnt_w(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            in_wait, wd_hit;

  assign in_wait = (state_q == S_W_WAIT) || (state_q == S_F_WAIT) || (state_q == S_C_WAIT);
  assign wd_hit  = in_wait && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Restart the count on every state change so each read gets a full window.
  always_comb begin
    wd_d = '0;
    if (in_wait && (state_d == state_q)) wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    ch_d    = ch_q;
    if (i_abort) begin
      state_d = S_IDLE;
      pix_d   = '0;
      ch_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: if (i_start) begin
          state_d = S_W_REQ;
          pix_d   = '0;
          ch_d    = '0;
        end
        S_W_REQ:  state_d = S_W_WAIT;
        S_W_WAIT: if (all_seen) begin
          if (pix_q == CNT_W'(WP - 1)) begin
            pix_d   = '0;
            state_d = S_F_REQ;
          end else begin
            pix_d   = pix_q + CNT_W'(1);
            state_d = S_W_REQ;
          end
        end
        S_F_REQ:  state_d = S_F_WAIT;
        S_F_WAIT: if (all_seen) begin
          if (pix_q == CNT_W'(FP - 1)) begin
            pix_d   = '0;
            state_d = S_C_START;
          end else begin
            pix_d   = pix_q + CNT_W'(1);
            state_d = S_F_REQ;
          end
        end
        S_C_START: state_d = S_C_WAIT;
        S_C_WAIT: if (i_compute_done) begin
          ch_d  = ch_q + CH_W'(1);
          pix_d = '0;
          state_d = (ch_q == CH_W'(NCH - 1)) ? S_FIN : S_W_REQ;
        end
        S_FIN: begin
          state_d = S_IDLE;
          pix_d   = '0;
          ch_d    = '0;
        end
        default: state_d = state_q;
      endcase
`ifdef DECONV_READ_SCHEDULER_TIMEOUT_EN
      if (wd_hit && (state_d == state_q)) state_d = S_ERR;
`endif
    end
  end

  always_comb begin
    o_weight_rd_en  = {N_LANES{state_q == S_W_REQ}};
    o_feature_rd_en = {N_LANES{state_q == S_F_REQ}};
    o_compute_start = (state_q == S_C_START);
    o_done          = (state_q == S_FIN);
    o_busy          = (state_q != S_IDLE);
`ifdef DECONV_READ_SCHEDULER_TIMEOUT_EN
    o_error         = (state_q == S_ERR);
`else
    o_error         = 1'b0;
`endif
    o_channel_idx   = ch_q;
    o_pix_idx       = PIX_W'(pix_q);
  end

endmodule

// File: tb/tb_deconv_read_scheduler.sv
// Scoreboard bench for deconv_read_scheduler with a per-lane BRAM latency model.
module tb_deconv_read_scheduler;
  import deconv_sched_pkg::*;

  localparam int NCH = 3;
  localparam int TMO = 16;
  localparam int CHW = $clog2(NCH + 1);
  localparam int PXW = $clog2(F_PIX + 1);

  logic           i_clk, i_rst_n, i_start, i_abort, i_compute_done;
  logic [3:0]     i_weight_rd_valid, i_feature_rd_valid;
  logic [3:0]     o_weight_rd_en, o_feature_rd_en;
  logic           o_compute_start, o_busy, o_done, o_error;
  logic [CHW-1:0] o_channel_idx;
  logic [PXW-1:0] o_pix_idx;

  deconv_read_scheduler #(
    .SIZE_OF_WEIGHT(DEF_SIZE_OF_WEIGHT), .SIZE_OF_FEATURE(DEF_SIZE_OF_FEATURE),
    .NUM_OF_CHANNEL_EACH_KERNEL(NCH), .N_LANES(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .o_weight_rd_en(o_weight_rd_en), .i_weight_rd_valid(i_weight_rd_valid),
    .o_feature_rd_en(o_feature_rd_en), .i_feature_rd_valid(i_feature_rd_valid),
    .o_compute_start(o_compute_start), .i_compute_done(i_compute_done),
    .o_channel_idx(o_channel_idx), .o_pix_idx(o_pix_idx),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [1:0] kind; logic [7:0] ch; logic [7:0] pix; } ev_t;
  localparam logic [1:0] K_W = 2'd0, K_F = 2'd1, K_CS = 2'd2, K_DONE = 2'd3;
  ev_t exp_q[$];

  int         lat[4];
  logic [3:0] drop, stray_w, stray_f;
  int         done_lat;
  int unsigned t0, cs_first, err_first;
  int         cs_cnt, done_cnt, w_cnt, f_cnt;
  bit         err_seen;

  // BRAM model: each lane answers lat[l] cycles after its strobe, unless dropped.
  initial begin : bram
    int remw[4];
    int remf[4];
    logic [3:0] vw, vf;
    for (int l = 0; l < 4; l++) begin remw[l] = 0; remf[l] = 0; end
    i_weight_rd_valid = '0;
    i_feature_rd_valid = '0;
    forever begin
      @(negedge i_clk);
      vw = '0; vf = '0;
      for (int l = 0; l < 4; l++) begin
        if (o_weight_rd_en[l]) begin
          checks++;
          if (remw[l] != 0) begin
            errors++;
            $display("FAIL outstanding_w lane%0d: strobe with read still pending (rem=%0d), required none", l, remw[l]);
          end
        end
        if (o_feature_rd_en[l]) begin
          checks++;
          if (remf[l] != 0) begin
            errors++;
            $display("FAIL outstanding_f lane%0d: strobe with read still pending (rem=%0d), required none", l, remf[l]);
          end
        end
        if (remw[l] > 0) begin remw[l]--; if (remw[l] == 0) vw[l] = 1'b1; end
        if (remf[l] > 0) begin remf[l]--; if (remf[l] == 0) vf[l] = 1'b1; end
        if (o_weight_rd_en[l]  && !drop[l]) remw[l] = lat[l];
        if (o_feature_rd_en[l] && !drop[l]) remf[l] = lat[l];
      end
      i_weight_rd_valid  = vw | stray_w;
      i_feature_rd_valid = vf | stray_f;
    end
  end

  // Tilling machine model: done pulse done_lat cycles after compute_start.
  initial begin : tiler
    i_compute_done = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_compute_start) begin
        repeat (done_lat) @(negedge i_clk);
        i_compute_done = 1'b1;
        @(negedge i_clk);
        i_compute_done = 1'b0;
      end
    end
  end

  // Monitor: every strobe/pulse must match the head of the expected queue.
  initial begin : monitor
    ev_t obs, e;
    bit  have;
    forever begin
      @(negedge i_clk);
      have = 1'b0;
      obs  = '0;
      if (|o_weight_rd_en) begin
        have = 1'b1; w_cnt++;
        obs = '{kind: K_W, ch: 8'(o_channel_idx), pix: 8'(o_pix_idx)};
        checks++;
        if (o_weight_rd_en !== 4'hF) begin
          errors++;
          $display("FAIL w_strobe_all_lanes: got %b, required 1111", o_weight_rd_en);
        end
      end else if (|o_feature_rd_en) begin
        have = 1'b1; f_cnt++;
        obs = '{kind: K_F, ch: 8'(o_channel_idx), pix: 8'(o_pix_idx)};
        checks++;
        if (o_feature_rd_en !== 4'hF) begin
          errors++;
          $display("FAIL f_strobe_all_lanes: got %b, required 1111", o_feature_rd_en);
        end
      end else if (o_compute_start) begin
        have = 1'b1;
        if (cs_cnt == 0) cs_first = cyc;
        cs_cnt++;
        obs = '{kind: K_CS, ch: 8'(o_channel_idx), pix: 8'd0};
      end else if (o_done) begin
        have = 1'b1; done_cnt++;
        obs = '{kind: K_DONE, ch: 8'd0, pix: 8'd0};
      end
      if (o_error && !err_seen) begin err_seen = 1'b1; err_first = cyc; end
      if (have) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got kind=%0d ch=%0d pix=%0d, required no event", obs.kind, obs.ch, obs.pix);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL event_seq: got kind=%0d ch=%0d pix=%0d, required kind=%0d ch=%0d pix=%0d",
                     obs.kind, obs.ch, obs.pix, e.kind, e.ch, e.pix);
          end
        end
      end
    end
  end

  task automatic push_channel(input int ch, input int nw, input int nf, input bit with_cs);
    for (int p = 0; p < nw; p++) exp_q.push_back('{kind: K_W, ch: 8'(ch), pix: 8'(p)});
    for (int p = 0; p < nf; p++) exp_q.push_back('{kind: K_F, ch: 8'(ch), pix: 8'(p)});
    if (with_cs) exp_q.push_back('{kind: K_CS, ch: 8'(ch), pix: 8'd0});
  endtask

  task automatic push_run();
    for (int c = 0; c < NCH; c++) push_channel(c, W_PIX, F_PIX, 1'b1);
    exp_q.push_back('{kind: K_DONE, ch: 8'd0, pix: 8'd0});
  endtask

  task automatic clear_stats();
    cs_cnt = 0; done_cnt = 0; w_cnt = 0; f_cnt = 0; err_seen = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge i_clk);
    i_start = 1'b1;
    t0 = cyc;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin @(negedge i_clk); n++; end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: no o_done within %0d cycles, required one", tag, limit);
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_weight_rd_en, o_feature_rd_en, o_compute_start, o_busy, o_done, o_error} !== '0 ||
        o_channel_idx !== '0 || o_pix_idx !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wen=%b fen=%b cs=%b busy=%b done=%b err=%b ch=%0d pix=%0d, required all 0",
               o_weight_rd_en, o_feature_rd_en, o_compute_start, o_busy, o_done, o_error, o_channel_idx, o_pix_idx);
    end
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_basic();
    for (int l = 0; l < 4; l++) lat[l] = 1;
    clear_stats();
    push_run();
    pulse_start();
    wait_done(2000, "basic");
    checks++;
    if (cs_first - t0 != 51) begin
      errors++; $display("FAIL basic_cs_cycle: got %0d, required 51", cs_first - t0);
    end
    checks++;
    if (w_cnt != W_PIX * NCH || f_cnt != F_PIX * NCH) begin
      errors++; $display("FAIL basic_pulses: got w=%0d f=%0d, required w=%0d f=%0d", w_cnt, f_cnt, W_PIX*NCH, F_PIX*NCH);
    end
    checks++;
    if (cs_cnt != NCH || done_cnt != 1) begin
      errors++; $display("FAIL basic_cs_done_count: got cs=%0d done=%0d, required %0d and 1", cs_cnt, done_cnt, NCH);
    end
    checks++;
    if (o_busy !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL basic_end: got busy=%b pending=%0d, required busy=0 pending=0", o_busy, exp_q.size());
    end
  endtask

  task automatic test_skew();
    lat[0] = 1; lat[1] = 2; lat[2] = 3; lat[3] = 4;
    clear_stats();
    push_run();
    pulse_start();
    wait_done(4000, "skew");
    checks++;
    if (cs_first - t0 != 126) begin
      errors++; $display("FAIL skew_cs_cycle: got %0d, required 126", cs_first - t0);
    end
    checks++;
    if (w_cnt != W_PIX * NCH || f_cnt != F_PIX * NCH || done_cnt != 1) begin
      errors++; $display("FAIL skew_pulses: got w=%0d f=%0d done=%0d, required w=%0d f=%0d done=1",
                         w_cnt, f_cnt, done_cnt, W_PIX*NCH, F_PIX*NCH);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    for (int l = 0; l < 4; l++) lat[l] = 1;
    clear_stats();
    push_channel(0, W_PIX, 8, 1'b0);
    pulse_start();
    while (!(|o_feature_rd_en && o_pix_idx == PXW'(7)) && n < 500) begin @(negedge i_clk); n++; end
    checks++;
    if (n >= 500) begin
      errors++; $display("FAIL abort_reach_px7: feature pixel 7 not reached in 500 cycles, required reached");
    end
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_pix_idx !== '0 || o_channel_idx !== '0) begin
      errors++; $display("FAIL abort_idle: got busy=%b pix=%0d ch=%0d, required 0 0 0", o_busy, o_pix_idx, o_channel_idx);
    end
    repeat (20) @(negedge i_clk);
    checks++;
    if (cs_cnt != 0 || done_cnt != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL abort_quiet: got cs=%0d done=%0d pending=%0d, required 0 0 0", cs_cnt, done_cnt, exp_q.size());
    end
    clear_stats();
    push_run();
    pulse_start();
    wait_done(2000, "abort_restart");
    checks++;
    if (cs_first - t0 != 51 || cs_cnt != NCH) begin
      errors++; $display("FAIL abort_restart: got cs_cycle=%0d cs=%0d, required 51 and %0d", cs_first - t0, cs_cnt, NCH);
    end
  endtask

  task automatic test_stray_busy();
    lat[0] = 1; lat[1] = 1; lat[2] = 1; lat[3] = 4;
    clear_stats();
    stray_w = 4'hF; stray_f = 4'hF;
    repeat (3) @(negedge i_clk);
    stray_w = '0; stray_f = '0;
    push_run();
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      repeat (7 + 20 * k) @(negedge i_clk);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
    end
    wait_done(4000, "stray");
    checks++;
    if (cs_first - t0 != 126) begin
      errors++; $display("FAIL stray_cs_cycle: got %0d, required 126", cs_first - t0);
    end
    repeat (10) @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0 || done_cnt != 1 || cs_cnt != NCH || exp_q.size() != 0) begin
      errors++; $display("FAIL stray_end: got busy=%b done=%0d cs=%0d pending=%0d, required 0 1 %0d 0",
                         o_busy, done_cnt, cs_cnt, exp_q.size(), NCH);
    end
  endtask

`ifdef DECONV_READ_SCHEDULER_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    for (int l = 0; l < 4; l++) lat[l] = 1;
    drop = 4'b0100;
    clear_stats();
    exp_q.push_back('{kind: K_W, ch: 8'd0, pix: 8'd0});
    pulse_start();
    while (!err_seen && n < 200) begin @(negedge i_clk); n++; end
    checks++;
    if (!err_seen || err_first - t0 != 18) begin
      errors++; $display("FAIL timeout_cycle: got seen=%b at %0d, required 18", err_seen, err_first - t0);
    end
    checks++;
    if (o_busy !== 1'b1 || o_weight_rd_en !== '0 || o_feature_rd_en !== '0) begin
      errors++; $display("FAIL timeout_err_state: got busy=%b wen=%b fen=%b, required 1 0000 0000",
                         o_busy, o_weight_rd_en, o_feature_rd_en);
    end
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    drop = '0;
    checks++;
    if (o_error !== 1'b0 || o_busy !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL timeout_abort: got err=%b busy=%b pending=%0d, required 0 0 0", o_error, o_busy, exp_q.size());
    end
  endtask
`endif

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

  initial begin : main
    i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    drop = '0; stray_w = '0; stray_f = '0; done_lat = 3;
    for (int l = 0; l < 4; l++) lat[l] = 1;
    clear_stats();
    test_reset();
    test_basic();
    test_skew();
    test_abort();
    test_stray_busy();
`ifdef DECONV_READ_SCHEDULER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
